// File: rtl/mem_pkg.sv
// Shared types and helpers for the main memory backing store.
// Lanes are big-endian: lane 0 is the lowest byte address and the MSB.
package mem_pkg;

   localparam int WORD_BYTES = 4;

   typedef logic [0:WORD_BYTES-1][7:0] byte_lanes_t;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      WR_WAIT
   } mem_state_t;

   function automatic logic [31:0] lanes_to_word(input byte_lanes_t l);
      return {l[0], l[1], l[2], l[3]};
   endfunction

   function automatic byte_lanes_t word_to_lanes(input logic [31:0] w);
      byte_lanes_t l;
      l[0] = w[31:24];
      l[1] = w[23:16];
      l[2] = w[15:8];
      l[3] = w[7:0];
      return l;
   endfunction

endpackage

// File: rtl/mem_latency_ctr.sv
// Loadable down-counter with a zero flag.
// Times the fixed read/write latency of the main memory.
module mem_latency_ctr #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   // load takes priority over decrement
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (dec_i) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/main_memory.sv
// Byte-organised backing store behind the data cache, one word per request.
// Optional MEM_BOUNDS_CHECK_EN adds an err output for out-of-range addresses.
module main_memory
   import mem_pkg::*;
#(
   parameter int MEM_BYTES = 65536,
   parameter int READ_LAT  = 4,
   parameter int WRITE_LAT = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] addr,
   input  byte_lanes_t wdata,
   output logic        req_ready,
   output logic        done,
   output byte_lanes_t rdata
`ifdef MEM_BOUNDS_CHECK_EN
   ,
   output logic        err
`endif
);

   localparam int AW      = $clog2(MEM_BYTES);
   localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
   localparam int CW      = $clog2(MAX_LAT) + 1;

   mem_state_t  state_q, state_d;
   logic        write_q;
   logic [29:0] addr_q;
   byte_lanes_t wdata_q;
   byte_lanes_t rdata_q;
   logic        done_q;
   logic        err_q;

   logic [7:0]  mem_q [MEM_BYTES];

   logic          accept;
   logic          busy;
   logic          finish;
   logic          cnt_zero;
   logic          ctr_dec;
   logic [CW-1:0] ctr_val;
   logic [AW-1:0] base;
   logic          oob;
   byte_lanes_t   rd_lanes;
   logic          unused_bits;

   mem_latency_ctr #(
      .W(CW)
   ) u_ctr (
      .clk       (clk),
      .reset     (reset),
      .load_i    (accept),
      .load_val_i(ctr_val),
      .dec_i     (ctr_dec),
      .zero_o    (cnt_zero)
   );

   // word base of the latched request, wrapped to the array size
   assign base = AW'({addr_q, 2'b00} & (MEM_BYTES - 1));

`ifdef MEM_BOUNDS_CHECK_EN
   assign oob = (({addr_q, 2'b00} >> AW) != 32'd0);
`else
   assign oob = 1'b0;
`endif

   assign unused_bits = ^{addr[1:0], addr_q};

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = req_write ? WR_WAIT : RD_WAIT;
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (cnt_zero) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs and counter control
   always_comb begin
      req_ready = (state_q == IDLE);
      busy      = !req_ready;
      accept    = req_ready && req_valid;
      finish    = busy && cnt_zero;
      ctr_dec   = busy && !cnt_zero;
      ctr_val   = req_write ? CW'(WRITE_LAT - 1) : CW'(READ_LAT - 1);
   end

   // capture the request so later input changes cannot disturb it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         write_q <= req_write;
         addr_q  <= addr[31:2];
         wdata_q <= wdata;
      end
   end

   // combinational fetch of the four bytes at the word base
   always_comb begin
      rd_lanes = '0;
      for (int i = 0; i < WORD_BYTES; i++) begin
         rd_lanes[i] = mem_q[base + AW'(i)];
      end
   end

   // completion pulse, read data and error flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         done_q <= finish;
         err_q  <= finish && oob;
         if (finish && !write_q && !oob) begin
            rdata_q <= rd_lanes;
         end
      end
   end

   // commit happens only on the final edge, so a reset mid-write is harmless
   always_ff @(posedge clk) begin
      if (finish && write_q && !oob) begin
         for (int i = 0; i < WORD_BYTES; i++) begin
            mem_q[base + AW'(i)] <= wdata_q[i];
         end
      end
   end

   assign done  = done_q;
   assign rdata = rdata_q;

`ifdef MEM_BOUNDS_CHECK_EN
   assign err = err_q;
`else
   logic unused_err;
   assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_main_memory.sv
// Directed self-checking bench for main_memory.
// Each task drives one scenario and checks results inline.
module tb_main_memory;
   import mem_pkg::*;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [31:0] addr;
   byte_lanes_t wdata;
   logic        req_ready;
   logic        done;
   byte_lanes_t rdata;
   logic        err_w;

   int vec;
   int miss;

   main_memory #(
      .MEM_BYTES(65536),
      .READ_LAT (4),
      .WRITE_LAT(5)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid),
      .req_write(req_write),
      .addr     (addr),
      .wdata    (wdata),
      .req_ready(req_ready),
      .done     (done),
      .rdata    (rdata)
`ifdef MEM_BOUNDS_CHECK_EN
      ,
      .err      (err_w)
`endif
   );

`ifndef MEM_BOUNDS_CHECK_EN
   assign err_w = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // issue one request and wait for its done; lat = edges from accept to done
   task automatic run_req(input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int lat,
                          output logic [31:0] rd, output logic e);
      int n;
      n = 0;
      while (!req_ready && n < 50) begin
         tick();
         n++;
      end
      req_valid = 1'b1;
      req_write = w;
      addr      = a;
      wdata     = word_to_lanes(d);
      tick();
      req_valid = 1'b0;
      req_write = ~w;
      addr      = 32'hFFFF_FFFC;
      wdata     = word_to_lanes(32'h5A5A_5A5A);
      lat = -1;
      for (int c = 1; c <= 50; c++) begin
         tick();
         if (done) begin
            lat = c;
            break;
         end
      end
      rd = lanes_to_word(rdata);
      e  = err_w;
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      addr      = '0;
      wdata     = '0;
      tick();
      tick();
      vec++;
      if (req_ready !== 1'b1) begin
         miss++;
         $display("FAIL reset_ready got %b want 1", req_ready);
      end
      vec++;
      if (done !== 1'b0) begin
         miss++;
         $display("FAIL reset_done got %b want 0", done);
      end
      vec++;
      if (lanes_to_word(rdata) !== 32'h0) begin
         miss++;
         $display("FAIL reset_rdata got %h want 0", lanes_to_word(rdata));
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_write_read();
      int lat;
      logic [31:0] rd;
      logic e;
      run_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat, rd, e);
      vec++;
      if (lat !== 5) begin
         miss++;
         $display("FAIL wr_latency got %0d want 5", lat);
      end
      vec++;
      if (rd !== 32'h0) begin
         miss++;
         $display("FAIL wr_rdata_kept got %h want 0", rd);
      end
      run_req(1'b0, 32'h0000_0010, 32'h0, lat, rd, e);
      vec++;
      if (lat !== 4) begin
         miss++;
         $display("FAIL rd_latency got %0d want 4", lat);
      end
      vec++;
      if (rd !== 32'hDEAD_BEEF) begin
         miss++;
         $display("FAIL rd_data got %h want deadbeef", rd);
      end
      vec++;
      if (e !== 1'b0) begin
         miss++;
         $display("FAIL rd_err got %b want 0", e);
      end
   endtask

   task automatic test_align();
      int lat;
      logic [31:0] rd;
      logic e;
      run_req(1'b0, 32'h0000_0013, 32'h0, lat, rd, e);
      vec++;
      if (lat !== 4) begin
         miss++;
         $display("FAIL align_latency got %0d want 4", lat);
      end
      vec++;
      if (rd !== 32'hDEAD_BEEF) begin
         miss++;
         $display("FAIL align_data got %h want deadbeef", rd);
      end
   endtask

   task automatic test_busy_ignore();
      int lat;
      logic [31:0] rd;
      logic e;
      logic seen;
      run_req(1'b1, 32'h0000_0020, 32'h5566_7788, lat, rd, e);
      req_valid = 1'b1;
      req_write = 1'b0;
      addr      = 32'h0000_0010;
      tick();
      req_valid = 1'b0;
      tick();
      req_valid = 1'b1;
      req_write = 1'b1;
      addr      = 32'h0000_0020;
      wdata     = word_to_lanes(32'h1122_3344);
      vec++;
      if (req_ready !== 1'b0) begin
         miss++;
         $display("FAIL busy_ready got %b want 0", req_ready);
      end
      tick();
      req_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         tick();
         seen = done;
      end
      vec++;
      if (!seen || lanes_to_word(rdata) !== 32'hDEAD_BEEF) begin
         miss++;
         $display("FAIL busy_read got %h done %b want deadbeef",
                  lanes_to_word(rdata), seen);
      end
      run_req(1'b0, 32'h0000_0020, 32'h0, lat, rd, e);
      vec++;
      if (rd !== 32'h5566_7788) begin
         miss++;
         $display("FAIL busy_prior got %h want 55667788", rd);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      int t1;
      int t2;
      logic [31:0] rd;
      logic e;
      run_req(1'b1, 32'h0000_0014, 32'hCAFE_F00D, lat, rd, e);
      t1 = -1;
      t2 = -1;
      req_valid = 1'b1;
      req_write = 1'b0;
      addr      = 32'h0000_0010;
      tick();
      addr = 32'h0000_0014;
      for (int c = 1; c <= 20 && t1 < 0; c++) begin
         tick();
         if (done) t1 = c;
      end
      vec++;
      if (lanes_to_word(rdata) !== 32'hDEAD_BEEF) begin
         miss++;
         $display("FAIL b2b_first got %h want deadbeef",
                  lanes_to_word(rdata));
      end
      vec++;
      if (req_ready !== 1'b1) begin
         miss++;
         $display("FAIL b2b_ready_at_done got %b want 1", req_ready);
      end
      tick();
      req_valid = 1'b0;
      vec++;
      if (req_ready !== 1'b0) begin
         miss++;
         $display("FAIL b2b_accept got %b want 0", req_ready);
      end
      for (int c = t1 + 1; c <= t1 + 20 && t2 < 0; c++) begin
         if (c > t1 + 1) tick();
         if (done) t2 = c;
      end
      vec++;
      if (t1 < 0 || t2 - t1 !== 5) begin
         miss++;
         $display("FAIL b2b_gap got %0d want 5", t2 - t1);
      end
      vec++;
      if (lanes_to_word(rdata) !== 32'hCAFE_F00D) begin
         miss++;
         $display("FAIL b2b_second got %h want cafef00d",
                  lanes_to_word(rdata));
      end
   endtask

   task automatic test_reset_mid_write();
      int lat;
      logic [31:0] rd;
      logic e;
      logic seen;
      seen = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b1;
      addr      = 32'h0000_0010;
      wdata     = word_to_lanes(32'hAABB_CCDD);
      tick();
      req_valid = 1'b0;
      tick();
      seen = seen | done;
      tick();
      seen = seen | done;
      reset = 1'b0;
      #1;
      vec++;
      if (req_ready !== 1'b1 || done !== 1'b0) begin
         miss++;
         $display("FAIL rst_mid_state got ready %b done %b want 1 0",
                  req_ready, done);
      end
      tick();
      reset = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         seen = seen | done;
      end
      vec++;
      if (seen !== 1'b0) begin
         miss++;
         $display("FAIL rst_mid_done got %b want 0", seen);
      end
      run_req(1'b0, 32'h0000_0010, 32'h0, lat, rd, e);
      vec++;
      if (rd !== 32'hDEAD_BEEF) begin
         miss++;
         $display("FAIL rst_mid_data got %h want deadbeef", rd);
      end
   endtask

   task automatic test_wrap();
      int lat;
      logic [31:0] rd;
      logic e;
      run_req(1'b1, 32'h0001_0010, 32'h0102_0304, lat, rd, e);
      vec++;
      if (lat !== 5) begin
         miss++;
         $display("FAIL wrap_latency got %0d want 5", lat);
      end
`ifdef MEM_BOUNDS_CHECK_EN
      vec++;
      if (e !== 1'b1) begin
         miss++;
         $display("FAIL bounds_err got %b want 1", e);
      end
      run_req(1'b0, 32'h0000_0010, 32'h0, lat, rd, e);
      vec++;
      if (rd !== 32'hDEAD_BEEF) begin
         miss++;
         $display("FAIL bounds_data got %h want deadbeef", rd);
      end
      vec++;
      if (e !== 1'b0) begin
         miss++;
         $display("FAIL bounds_err_clear got %b want 0", e);
      end
`else
      run_req(1'b0, 32'h0000_0010, 32'h0, lat, rd, e);
      vec++;
      if (rd !== 32'h0102_0304) begin
         miss++;
         $display("FAIL wrap_data got %h want 01020304", rd);
      end
`endif
   endtask

   initial begin
      vec  = 0;
      miss = 0;
      test_reset();
      test_write_read();
      test_align();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_write();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
